boot_load_ctrl: RTL and testbench

//  Boot sequencer for the single-cycle RISC-V core. Receives a byte stream (UART/debug link), parses a
//  4-byte word-count header, packs bytes into 32-bit words and writes them to instruction memory.

---
 rtl/boot_load_ctrl_pkg.sv | 28 ++
 rtl/boot_load_ctrl_byte_packer.sv | 52 +++++
 rtl/boot_load_ctrl.sv | 166 ++++++++++++++++
 tb/tb_boot_load_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_load_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// boot_load_ctrl_pkg
//   Shared definitions for the boot loader: FSM state encoding, header length
//   and the header-length range check.
// ----------------------------------------------------------------------------
package boot_load_ctrl_pkg;

    // Loader states (2-bit encoding)
    typedef enum logic [1:0] {
        BOOT_HDR  = 2'd0,
        BOOT_LOAD = 2'd1,
        BOOT_RUN  = 2'd2,
        BOOT_ERR  = 2'd3
    } boot_state_e;

    // Number of bytes in the word-count header (and in every data word)
    localparam int BOOT_HDR_BYTES = 4;

    // True when a header word count N exceeds the memory depth 2**aw.
    // The compare is done on the full 32-bit N, widened to 33 bits so that
    // a depth of 2**32 would still be representable.
    function automatic logic hdr_too_long(input logic [31:0] n, input int unsigned aw);
        logic [32:0] depth;
        depth = 33'd1 << aw;
        return ({1'b0, n} > depth);
    endfunction

endpackage

// File: rtl/boot_load_ctrl_byte_packer.sv
// ----------------------------------------------------------------------------
// byte_packer
//   Packs accepted bytes into little-endian 32-bit words. Byte k of a word
//   lands in bits [8k+7:8k]. word_valid is a one-cycle pulse in the cycle
//   the fourth byte is accepted; word carries the complete word in that cycle.
// Ports
//   clk        in   system clock
//   clear      in   synchronous clear of byte counter and assembly register
//                   (driven by system reset or reload); also masks in_valid
//   in_byte    in   byte to pack
//   in_valid   in   in_byte is accepted this cycle
//   word       out  packed word, meaningful while word_valid is high
//   word_valid out  one-cycle pulse on the fourth accepted byte
// ----------------------------------------------------------------------------
module byte_packer
    import boot_load_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_IDX = 2'(BOOT_HDR_BYTES - 1);

    logic [1:0]  byte_cnt_r;
    // Holds the first three bytes of a word; the fourth byte is taken
    // straight from the input so the word is complete in the same cycle.
    logic [23:0] asm_r;
    logic        take_s;

    assign take_s     = in_valid & ~clear;
    assign word_valid = take_s & (byte_cnt_r == LAST_IDX);
    assign word       = {in_byte, asm_r};

    // Byte counter (wraps 3->0) and shift-in assembly register
    always_ff @(posedge clk) begin
        if (clear) begin
            byte_cnt_r <= 2'd0;
            asm_r      <= 24'd0;
        end else if (take_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            asm_r      <= {in_byte, asm_r[23:8]};
        end else begin
            byte_cnt_r <= byte_cnt_r;
            asm_r      <= asm_r;
        end
    end

endmodule

// File: rtl/boot_load_ctrl.sv
// ----------------------------------------------------------------------------
// boot_load_ctrl
//   Boot sequencer for the RISC-V core. Parses a 4-byte little-endian word
//   count header from the host byte stream, writes the following N words to
//   instruction memory, and keeps the CPU in reset until the image is loaded.
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   rx_data/valid  incoming byte stream; rx_ready accepts (from state only)
//   reload         one-cycle request to abort/restart and wait for a header
//   imem_we/addr/wdata  instruction memory write port (one pulse per word)
//   cpu_reset      CPU reset, released once the image is in place
//   load_busy      high while in HDR or LOAD
//   load_err       header word count exceeded memory depth
//   word_cnt       words written in the current load, held in RUN
// ----------------------------------------------------------------------------
module boot_load_ctrl
    import boot_load_ctrl_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               reload,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_reset,
    output logic               load_busy,
    output logic               load_err,
    output logic [IMEM_AW:0]   word_cnt
);

    boot_state_e        state_r;
    boot_state_e        next_state_s;
    logic [31:0]        n_r;
    logic [IMEM_AW-1:0] widx_r;
    logic [IMEM_AW:0]   word_cnt_r;
    logic               imem_we_r;
    logic [IMEM_AW-1:0] imem_addr_r;
    logic [31:0]        imem_wdata_r;
    logic               cpu_reset_r;
    logic               load_err_r;

    logic               accept_s;
    logic [31:0]        word_s;
    logic               word_valid_s;
    logic               write_now_s;
    logic               hdr_take_s;
    logic               last_written_s;

    assign rx_ready  = ((state_r == BOOT_HDR) || (state_r == BOOT_LOAD)) & ~reset;
    assign accept_s  = rx_valid & rx_ready;
    assign load_busy = (state_r == BOOT_HDR) || (state_r == BOOT_LOAD);

    // reload is folded into clear so a byte arriving with reload is dropped
    byte_packer u_packer (
        .clk        (clk),
        .clear      (reset | reload),
        .in_byte    (rx_data),
        .in_valid   (accept_s),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    assign write_now_s    = (state_r == BOOT_LOAD) & word_valid_s & ~reload;
    assign hdr_take_s     = (state_r == BOOT_HDR) & word_valid_s & ~reload;
    // word_cnt already includes the word being written while imem_we is high
    assign last_written_s = (32'(word_cnt_r) == n_r);

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            BOOT_HDR: begin
                if (reload) begin
                    next_state_s = BOOT_HDR;
                end else if (word_valid_s) begin
                    if (word_s == 32'd0) begin
                        next_state_s = BOOT_RUN;
                    end else if (hdr_too_long(word_s, IMEM_AW)) begin
                        next_state_s = BOOT_ERR;
                    end else begin
                        next_state_s = BOOT_LOAD;
                    end
                end else begin
                    next_state_s = BOOT_HDR;
                end
            end
            BOOT_LOAD: begin
                // Leave only after the final write pulse so cpu_reset drops
                // the cycle after it.
                if (reload) begin
                    next_state_s = BOOT_HDR;
                end else if (imem_we_r && last_written_s) begin
                    next_state_s = BOOT_RUN;
                end else begin
                    next_state_s = BOOT_LOAD;
                end
            end
            BOOT_RUN: begin
                if (reload) begin
                    next_state_s = BOOT_HDR;
                end else begin
                    next_state_s = BOOT_RUN;
                end
            end
            BOOT_ERR: begin
                if (reload) begin
                    next_state_s = BOOT_HDR;
                end else begin
                    next_state_s = BOOT_ERR;
                end
            end
            default: begin
                next_state_s = BOOT_HDR;
            end
        endcase
    end

    // State, header, word index and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= BOOT_HDR;
            n_r          <= 32'd0;
            widx_r       <= '0;
            word_cnt_r   <= '0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'd0;
            cpu_reset_r  <= 1'b1;
            load_err_r   <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            imem_we_r   <= write_now_s;
            cpu_reset_r <= (next_state_s != BOOT_RUN);
            load_err_r  <= (next_state_s == BOOT_ERR);
            if (reload) begin
                widx_r     <= '0;
                word_cnt_r <= '0;
            end else if (hdr_take_s) begin
                n_r        <= word_s;
                widx_r     <= '0;
                word_cnt_r <= '0;
            end else if (write_now_s) begin
                imem_addr_r  <= widx_r;
                imem_wdata_r <= word_s;
                widx_r       <= widx_r + IMEM_AW'(1);
                word_cnt_r   <= word_cnt_r + (IMEM_AW + 1)'(1);
            end else begin
                widx_r     <= widx_r;
                word_cnt_r <= word_cnt_r;
            end
        end
    end

    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_reset  = cpu_reset_r;
    assign load_err   = load_err_r;
    assign word_cnt   = word_cnt_r;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_boot_load_ctrl
//   Directed self-checking bench for boot_load_ctrl (IMEM_AW = 8).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge; imem writes are logged on the rising edge.
// ----------------------------------------------------------------------------
module tb_boot_load_ctrl;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          load_busy;
    logic          load_err;
    logic [AW:0]   word_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    boot_load_ctrl #(.IMEM_AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_busy  (load_busy),
        .load_err   (load_err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    // Log every cycle in which imem_we is high
    always @(posedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            n_cmp++;
            n_err++;
            $error("FAIL send_byte_timeout: observed rx_ready=0 expected rx_ready=1 (byte 0x%02h)", b);
            rx_valid = 1'b0;
        end else begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    // Hard stop if the bench itself stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        reset    = 1'b1;
        rx_data  = 8'd0;
        rx_valid = 1'b0;
        reload   = 1'b0;
        repeat (3) @(negedge clk);

        // ---- reset state ----
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_imem_we",   32'(imem_we),   32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata",     imem_wdata,     32'd0);
        chk("rst_load_err",  32'(load_err),  32'd0);
        chk("rst_word_cnt",  32'(word_cnt),  32'd0);
        chk("rst_rx_ready",  32'(rx_ready),  32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("hdr_rx_ready",  32'(rx_ready),  32'd1);
        chk("hdr_load_busy", 32'(load_busy), 32'd1);

        // ---- 1: two-word load, back to back ----
        clear_log();
        send_word(32'h0000_0002, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        chk("t1_we_last",      32'(imem_we),   32'd1);
        chk("t1_cpurst_pulse", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk("t1_we_after",     32'(imem_we),   32'd0);
        chk("t1_cpurst_low",   32'(cpu_reset), 32'd0);
        chk("t1_busy_run",     32'(load_busy), 32'd0);
        chk("t1_rdy_run",      32'(rx_ready),  32'd0);
        chk("t1_word_cnt",     32'(word_cnt),  32'd2);
        chk("t1_nwrites",      32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("t1_addr0", 32'(wa[0]), 32'd0);
            chk("t1_data0", wd[0],      32'h0000_0013);
            chk("t1_addr1", 32'(wa[1]), 32'd1);
            chk("t1_data1", wd[1],      32'h0010_0093);
        end

        // ---- 4: same load with random gaps, then rx_valid held in RUN ----
        pulse_reload();
        chk("t4_reload_cpurst", 32'(cpu_reset), 32'd1);
        chk("t4_reload_cnt",    32'(word_cnt),  32'd0);
        chk("t4_reload_busy",   32'(load_busy), 32'd1);
        clear_log();
        send_word(32'h0000_0002, 5);
        send_word(32'h0000_0013, 5);
        send_word(32'h0010_0093, 5);
        repeat (2) @(negedge clk);
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        repeat (12) @(negedge clk);
        chk("t4_rdy_run",   32'(rx_ready),  32'd0);
        rx_valid = 1'b0;
        chk("t4_cpurst",    32'(cpu_reset), 32'd0);
        chk("t4_word_cnt",  32'(word_cnt),  32'd2);
        chk("t4_nwrites",   32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("t4_addr0", 32'(wa[0]), 32'd0);
            chk("t4_data0", wd[0],      32'h0000_0013);
            chk("t4_addr1", 32'(wa[1]), 32'd1);
            chk("t4_data1", wd[1],      32'h0010_0093);
        end

        // ---- 2: zero-length header ----
        pulse_reload();
        clear_log();
        send_word(32'h0000_0000, 0);
        chk("t2_cpurst", 32'(cpu_reset), 32'd0);
        chk("t2_busy",   32'(load_busy), 32'd0);
        chk("t2_rdy",    32'(rx_ready),  32'd0);
        repeat (3) @(negedge clk);
        chk("t2_nwrites", 32'(wa.size()), 32'd0);
        chk("t2_word_cnt", 32'(word_cnt), 32'd0);

        // ---- 3: N=257 -> ERR, reload recovers ----
        pulse_reload();
        send_word(32'h0000_0101, 0);
        chk("t3_err",    32'(load_err),  32'd1);
        chk("t3_rdy",    32'(rx_ready),  32'd0);
        chk("t3_cpurst", 32'(cpu_reset), 32'd1);
        chk("t3_busy",   32'(load_busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("t3_err_hold", 32'(load_err), 32'd1);
        pulse_reload();
        chk("t3_err_clr",  32'(load_err), 32'd0);
        chk("t3_rdy_hdr",  32'(rx_ready), 32'd1);
        // high header byte only: must not be truncated to 0
        send_word(32'h0100_0000, 0);
        chk("t3_err_wide", 32'(load_err),  32'd1);
        chk("t3_cpurst_w", 32'(cpu_reset), 32'd1);
        pulse_reload();
        chk("t3_err_clr2", 32'(load_err), 32'd0);

        // ---- 5: reload with the 7th byte of a 2-word load ----
        clear_log();
        send_word(32'h0000_0002, 0);
        send_word(32'h0000_0013, 0);
        send_byte(8'h93);
        send_byte(8'h00);
        rx_data  = 8'h10;
        rx_valid = 1'b1;
        reload   = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b0;
        send_byte(8'h00);   // would complete word 1 if the 7th byte were kept
        repeat (3) @(negedge clk);
        chk("t5_nwrites",  32'(wa.size()), 32'd1);
        chk("t5_word_cnt", 32'(word_cnt),  32'd0);
        chk("t5_busy",     32'(load_busy), 32'd1);
        chk("t5_cpurst",   32'(cpu_reset), 32'd1);
        // discard the stray byte by restarting, then a fresh 1-word load
        pulse_reload();
        clear_log();
        send_word(32'h0000_0001, 0);
        send_word(32'hDDCC_BBAA, 0);
        @(negedge clk);
        chk("t5_nwrites2", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            chk("t5_addr0", 32'(wa[0]), 32'd0);
            chk("t5_data0", wd[0],      32'hDDCC_BBAA);
        end
        chk("t5_cpurst_run", 32'(cpu_reset), 32'd0);
        chk("t5_word_cnt2",  32'(word_cnt),  32'd1);

        // ---- 6: N=256 full-depth load, back to back ----
        pulse_reload();
        clear_log();
        send_word(32'h0000_0100, 0);
        chk("t6_busy_load", 32'(load_busy), 32'd1);
        chk("t6_no_err",    32'(load_err),  32'd0);
        for (int i = 0; i < 256; i++) begin
            w = {8'hA5 ^ 8'(i), 8'(i), ~8'(i), 8'(i)};
            send_word(w, 0);
        end
        chk("t6_cpurst_last", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk("t6_cpurst_low", 32'(cpu_reset), 32'd0);
        chk("t6_word_cnt",   32'(word_cnt),  32'd256);
        chk("t6_busy_run",   32'(load_busy), 32'd0);
        chk("t6_nwrites",    32'(wa.size()), 32'd256);
        if (wa.size() == 256) begin
            chk("t6_last_addr", 32'(wa[255]), 32'h0000_00FF);
            for (int i = 0; i < 256; i++) begin
                w = {8'hA5 ^ 8'(i), 8'(i), ~8'(i), 8'(i)};
                chk($sformatf("t6_addr%0d", i), 32'(wa[i]), 32'(i));
                chk($sformatf("t6_data%0d", i), wd[i], w);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
